// File: rtl/piso_arb_ctrl.sv
// piso_arb_ctrl: round-robin arbiter and sequencer in front of a shared
// parallel-in/serial-out shift register. A grant captures the winner's
// word, pulses load for one cycle, then walks W serial bit periods of DIV
// cycles each with shift strobes between bits, and closes with a one-cycle
// done gap before returning to IDLE.
//
// Handshake: reqN is a level sampled only in IDLE. gntN is a one-cycle
// acknowledge that dataN was captured on the sampling edge. A requester
// that keeps reqN high after its gnt is simply considered again at the
// next IDLE cycle. Nothing outside IDLE observes req or data.
module piso_arb_ctrl #(
    parameter int W   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         load,
    output logic         shift,
    output logic [W-1:0] pdata,
    output logic         frame,
    output logic         src,
    output logic         busy,
    output logic         done
);

    // Counter widths; a 1-bit counter is kept when DIV == 1 so the
    // divide counter is never zero-width (it simply stays at 0).
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          rr_ptr;    // requester favoured on a tie
    logic          rr_nxt;
    logic [W-1:0]  pdata_nxt;
    logic          src_nxt;

    logic          any_req;
    logic          winner;
    logic          last_div;
    logic          last_bit;

    // Arbitration: a lone requester wins outright; on a tie the pointer
    // (the requester not served last) decides.
    assign any_req  = req0 | req1;
    assign winner   = (req0 & req1) ? rr_ptr : req1;
    assign last_div = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    // State, counters and captured frame context; async reset abandons
    // any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            rr_ptr  <= 1'b0;
            pdata   <= '0;
            src     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            div_cnt <= div_nxt;
            rr_ptr  <= rr_nxt;
            pdata   <= pdata_nxt;
            src     <= src_nxt;
        end
    end

    // Next-state, counter stepping and grant capture.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        rr_nxt    = rr_ptr;
        pdata_nxt = pdata;
        src_nxt   = src;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LOAD;
                    src_nxt   = winner;
                    pdata_nxt = winner ? data1 : data0;
                    rr_nxt    = ~winner;
                    bit_nxt   = '0;
                    div_nxt   = '0;
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_div) begin
                    div_nxt = '0;
                    if (last_bit) begin
                        bit_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state. The last bit period gets no
    // shift strobe: the final bit is already on the serial output.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        load  = 1'b0;
        shift = 1'b0;
        frame = 1'b0;
        done  = 1'b0;
        busy  = (state != IDLE);
        case (state)
            LOAD: begin
                load = 1'b1;
                gnt0 = ~src;
                gnt1 = src;
            end
            SHIFT: begin
                frame = 1'b1;
                shift = last_div & ~last_bit;
            end
            GAP: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifndef SYNTHESIS
    // Structural invariants of the strobe outputs.
    a_load_shift_excl : assert property (@(posedge clk) disable iff (rst) !(load && shift));
    a_gnt_excl        : assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_frame_not_load  : assert property (@(posedge clk) disable iff (rst) !(frame && load));
`endif

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: one instance at DIV=1 and one at DIV=3, each
// feeding a small MSB-first PISO model. Expected words and serial bits are
// queued when requests are driven and checked when load/frame appear.
module tb_piso_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;

  // DIV=1 instance signals
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, load, shift, frame, src, busy, done;
  logic [3:0] pdata;
  logic [3:0] piso = '0;

  // DIV=3 instance signals
  logic       req0_3 = 1'b0, req1_3 = 1'b0;
  logic [3:0] data0_3 = '0, data1_3 = '0;
  logic       gnt0_3, gnt1_3, load_3, shift_3, frame_3, src_3, busy_3, done_3;
  logic [3:0] pdata_3;
  logic [3:0] piso_3 = '0;

  // Scoreboards: {src, word} per grant, and serial bits per frame cycle.
  logic [4:0] exp_w_q[$];
  logic [0:0] exp_b_q[$];
  logic [4:0] exp_w3_q[$];
  logic [0:0] exp_b3_q[$];
  logic [4:0] mon_w;
  logic [0:0] mon_b;
  logic [4:0] mon_w3;
  logic [0:0] mon_b3;

  piso_arb_ctrl #(.W(4), .DIV(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .load(load), .shift(shift), .pdata(pdata),
    .frame(frame), .src(src), .busy(busy), .done(done)
  );

  piso_arb_ctrl #(.W(4), .DIV(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_3), .data0(data0_3), .req1(req1_3), .data1(data1_3),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .load(load_3), .shift(shift_3), .pdata(pdata_3),
    .frame(frame_3), .src(src_3), .busy(busy_3), .done(done_3)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Downstream PISO datapath models, MSB first.
  always_ff @(posedge clk) begin
    if (load) piso <= pdata;
    else if (shift) piso <= {piso[2:0], 1'b0};
  end
  always_ff @(posedge clk) begin
    if (load_3) piso_3 <= pdata_3;
    else if (shift_3) piso_3 <= {piso_3[2:0], 1'b0};
  end

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      n_tests++;
      if ((load && shift) || (gnt0 && gnt1)) begin
        n_fail++;
        $display("FAIL excl_d1: load=%b shift=%b gnt0=%b gnt1=%b, required no overlap", load, shift, gnt0, gnt1);
      end
      if (load) begin
        n_tests++;
        if (exp_w_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_d1: unexpected load pdata=%h src=%b", pdata, src);
        end else begin
          mon_w = exp_w_q.pop_front();
          if ({src, pdata} !== mon_w) begin
            n_fail++;
            $display("FAIL load_d1: got src/pdata=%h, required %h", {src, pdata}, mon_w);
          end
        end
      end
      if (frame) begin
        n_tests++;
        if (exp_b_q.size() == 0) begin
          n_fail++;
          $display("FAIL serial_d1: unexpected frame cycle bit=%b", piso[3]);
        end else begin
          mon_b = exp_b_q.pop_front();
          if (piso[3] !== mon_b[0]) begin
            n_fail++;
            $display("FAIL serial_d1: got bit %b, required %b", piso[3], mon_b[0]);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      n_tests++;
      if ((load_3 && shift_3) || (gnt0_3 && gnt1_3)) begin
        n_fail++;
        $display("FAIL excl_d3: load=%b shift=%b gnt0=%b gnt1=%b, required no overlap", load_3, shift_3, gnt0_3, gnt1_3);
      end
      if (load_3) begin
        n_tests++;
        if (exp_w3_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_d3: unexpected load pdata=%h src=%b", pdata_3, src_3);
        end else begin
          mon_w3 = exp_w3_q.pop_front();
          if ({src_3, pdata_3} !== mon_w3) begin
            n_fail++;
            $display("FAIL load_d3: got src/pdata=%h, required %h", {src_3, pdata_3}, mon_w3);
          end
        end
      end
      if (frame_3) begin
        n_tests++;
        if (exp_b3_q.size() == 0) begin
          n_fail++;
          $display("FAIL serial_d3: unexpected frame cycle bit=%b", piso_3[3]);
        end else begin
          mon_b3 = exp_b3_q.pop_front();
          if (piso_3[3] !== mon_b3[0]) begin
            n_fail++;
            $display("FAIL serial_d3: got bit %b, required %b", piso_3[3], mon_b3[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_d1(input logic s, input logic [3:0] w);
    exp_w_q.push_back({s, w});
    for (int b = 3; b >= 0; b--) exp_b_q.push_back(w[b]);
  endtask

  task automatic push_d3(input logic s, input logic [3:0] w);
    exp_w3_q.push_back({s, w});
    for (int b = 3; b >= 0; b--)
      for (int k = 0; k < 3; k++) exp_b3_q.push_back(w[b]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) step();
    n_tests++;
    if ({gnt0, gnt1, load, shift, pdata, frame, src, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_d1: outputs=%h, required 000", {gnt0, gnt1, load, shift, pdata, frame, src, busy, done});
    end
    n_tests++;
    if ({gnt0_3, gnt1_3, load_3, shift_3, pdata_3, frame_3, src_3, busy_3, done_3} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_d3: outputs=%h, required 000", {gnt0_3, gnt1_3, load_3, shift_3, pdata_3, frame_3, src_3, busy_3, done_3});
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    step();
    n_tests++;
    if (busy !== 1'b0 || busy_3 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b busy3=%b, required 0 0", busy, busy_3);
    end
  endtask

  task automatic test_single_frame();
    data0 = 4'b1011;
    req0 = 1'b1;
    push_d1(1'b0, 4'b1011);
    step();
    req0 = 1'b0;
    n_tests++;
    if ({gnt0, gnt1, load, busy, pdata} !== {4'b1011, 4'b1011}) begin
      n_fail++;
      $display("FAIL single_load: gnt0/gnt1/load/busy/pdata=%b, required 10111011", {gnt0, gnt1, load, busy, pdata});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (frame !== 1'b1 || shift !== (i < 3) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_shift[%0d]: frame=%b shift=%b done=%b, required 1 %b 0", i, frame, shift, done, (i < 3));
      end
    end
    step();
    n_tests++;
    if (done !== 1'b1 || frame !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b frame=%b busy=%b, required 1 0 1", done, frame, busy);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_round_robin();
    int last_cyc;
    bit seen;
    #2;
    rst = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    data0 = 4'h5;
    data1 = 4'hA;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) push_d1(1'b0, 4'h5);
      else push_d1(1'b1, 4'hA);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step();
        if (gnt0 || gnt1) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL rr_timeout[%0d]: no grant within 20 cycles", g);
      end else begin
        n_tests++;
        if ({gnt0, gnt1, src} !== ((g % 2 == 0) ? 3'b100 : 3'b011)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: gnt0/gnt1/src=%b, required %b", g, {gnt0, gnt1, src}, (g % 2 == 0) ? 3'b100 : 3'b011);
        end
        if (g > 0) begin
          n_tests++;
          if (cyc - last_cyc !== 7) begin
            n_fail++;
            $display("FAIL rr_interval[%0d]: got %0d cycles, required 7", g, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_div3();
    data1_3 = 4'b0110;
    req1_3 = 1'b1;
    push_d3(1'b1, 4'b0110);
    step();
    req1_3 = 1'b0;
    n_tests++;
    if ({gnt0_3, gnt1_3, load_3, src_3} !== 4'b0111) begin
      n_fail++;
      $display("FAIL div3_load: gnt0/gnt1/load/src=%b, required 0111", {gnt0_3, gnt1_3, load_3, src_3});
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_tests++;
      if (frame_3 !== 1'b1 || shift_3 !== (i == 3 || i == 6 || i == 9) || done_3 !== 1'b0) begin
        n_fail++;
        $display("FAIL div3_frame[%0d]: frame=%b shift=%b done=%b, required 1 %b 0", i, frame_3, shift_3, done_3, (i == 3 || i == 6 || i == 9));
      end
    end
    step();
    n_tests++;
    if (done_3 !== 1'b1 || frame_3 !== 1'b0) begin
      n_fail++;
      $display("FAIL div3_done: done=%b frame=%b, required 1 0", done_3, frame_3);
    end
    step();
    n_tests++;
    if (busy_3 !== 1'b0) begin
      n_fail++;
      $display("FAIL div3_idle: busy=%b, required 0", busy_3);
    end
  endtask

  task automatic test_data_hold();
    data0 = 4'hF;
    req0 = 1'b1;
    push_d1(1'b0, 4'hF);
    step();
    data0 = 4'h0;
    req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (pdata !== 4'hF) begin
        n_fail++;
        $display("FAIL data_hold[%0d]: pdata=%h, required f", i, pdata);
      end
    end
    step();
    n_tests++;
    if (pdata !== 4'hF || src !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL data_hold_idle: pdata=%h src=%b busy=%b, required f 0 0", pdata, src, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    data0 = 4'b1001;
    req0 = 1'b1;
    push_d1(1'b0, 4'b1001);
    step();
    req0 = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({gnt0, gnt1, load, shift, pdata, frame, src, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_outputs: outputs=%h, required 000", {gnt0, gnt1, load, shift, pdata, frame, src, busy, done});
    end
    exp_b_q.delete();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_nodone[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    data0 = 4'h3;
    data1 = 4'hC;
    req0 = 1'b1;
    req1 = 1'b1;
    push_d1(1'b0, 4'h3);
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    n_tests++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_tie: gnt0/gnt1=%b, required 10", {gnt0, gnt1});
    end
    repeat (6) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_queued_req();
    data0 = 4'b1100;
    req0 = 1'b1;
    push_d1(1'b0, 4'b1100);
    push_d1(1'b1, 4'b0101);
    step();
    n_tests++;
    if (gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL queued_gnt0: gnt0=%b, required 1", gnt0);
    end
    step();
    data1 = 4'b0101;
    req1 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    step();
    n_tests++;
    if (frame !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_frame: frame=%b gnt1=%b, required 1 0", frame, gnt1);
    end
    step();
    n_tests++;
    if (done !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_done: done=%b gnt1=%b, required 1 0", done, gnt1);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_idle: busy=%b gnt1=%b, required 0 0", busy, gnt1);
    end
    step();
    req1 = 1'b0;
    n_tests++;
    if ({gnt0, gnt1, load} !== 3'b011) begin
      n_fail++;
      $display("FAIL queued_gnt1: gnt0/gnt1/load=%b, required 011", {gnt0, gnt1, load});
    end
    repeat (6) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back_random();
    logic       who;
    logic [3:0] w;
    for (int n = 0; n < 6; n++) begin
      who = 1'($urandom_range(0, 1));
      w = 4'($urandom_range(0, 15));
      if (who) begin
        data1 = w;
        req1 = 1'b1;
      end else begin
        data0 = w;
        req0 = 1'b1;
      end
      push_d1(who, w);
      step();
      req0 = 1'b0;
      req1 = 1'b0;
      n_tests++;
      if ({gnt0, gnt1} !== {~who, who}) begin
        n_fail++;
        $display("FAIL rand_gnt[%0d]: gnt0/gnt1=%b, required %b", n, {gnt0, gnt1}, {~who, who});
      end
      repeat (6) step();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_div3();
    test_data_hold();
    test_reset_mid_frame();
    test_queued_req();
    test_back_to_back_random();
    repeat (3) step();
    n_tests++;
    if (exp_w_q.size() != 0 || exp_b_q.size() != 0 || exp_w3_q.size() != 0 || exp_b3_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_empty: left w=%0d b=%0d w3=%0d b3=%0d, required all 0",
               exp_w_q.size(), exp_b_q.size(), exp_w3_q.size(), exp_b3_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
